// File: rtl/spi_slave.sv
// SPI mode-0 slave with a one-entry transmit buffer. All SPI pins are
// oversampled in the clk domain: each pin is synchronized, and edges are found
// by comparing the synchronized level against a history flop.
module spi_slave #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sclk_i,
  input  logic             cs_ni,
  input  logic             mosi_i,
  output logic             miso_o,
  output logic             miso_oe_o,
  input  logic [Width-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [Width-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             tx_underrun_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  // Bit 0: first sync stage, bit 1: second sync stage, bit 2: history.
  logic [2:0] sclk_q, cs_q, mosi_q;

  logic [1:0]       warm_q, warm_d;
  logic [Width-1:0] tx_shift_q, tx_shift_d;
  logic [Width-1:0] rx_shift_q, rx_shift_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             word_done_q, word_done_d;
  logic [Width-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic [Width-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;

  logic edges_ok, sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync, load_tx;

  // Synchronizer chains for the three asynchronous SPI inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      cs_q   <= {cs_q[1:0], cs_ni};
      mosi_q <= {mosi_q[1:0], mosi_i};
    end
  end

  // The cs chain resets high, so a pin already low at reset release would look
  // like a fall. Edges are ignored until the chain has been refilled from the pin.
  assign edges_ok  = (warm_q == 2'd3);
  assign sclk_rise = edges_ok &  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = edges_ok & ~sclk_q[1] &  sclk_q[2];
  assign cs_rise   = edges_ok &  cs_q[1]   & ~cs_q[2];
  assign cs_fall   = edges_ok & ~cs_q[1]   &  cs_q[2];
  // mosi is stable for several clk periods around an sclk rise, so the history
  // stage holds the settled data bit.
  assign mosi_sync = mosi_q[2];

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      warm_q      <= 2'd0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
    end
  end

  // Frame FSM, shift registers and transmit buffer next-state.
  always_comb begin
    state_d     = state_q;
    warm_d      = edges_ok ? warm_q : warm_q + 2'd1;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_done_d = word_done_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    load_tx     = 1'b0;

    // Capture only into an empty buffer; consumes only happen when it is full.
    if (tx_valid_i && !buf_full_q) begin
      buf_d      = tx_data_i;
      buf_full_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d     = StActive;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          rx_shift_d  = '0;
          load_tx     = 1'b1;
        end
      end
      StActive: begin
        // cs rise wins over any coincident sclk edge.
        if (cs_rise) begin
          state_d     = StIdle;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          rx_shift_d  = '0;
          tx_shift_d  = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[Width-2:0], mosi_sync};
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d   = '0;
            rx_data_d   = rx_shift_d;
            rx_valid_d  = 1'b1;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            load_tx     = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[Width-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Word load: take the buffered word, or send zeros and flag the underrun.
    if (load_tx) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
  end

  assign miso_oe_o     = (state_q == StActive);
  assign miso_o        = (state_q == StActive) & tx_shift_q[Width-1];
  assign tx_ready_o    = ~buf_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, bits per SPI word (minimum 2).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 sclk  input  1  SPI serial clock, asynchronous to clk, mode 0 (idle low).
REQ-005 cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 mosi  input  1  master-out slave-in data, asynchronous to clk.
REQ-007 miso  output  1  slave-out data, MSB first.
REQ-008 miso_oe  output  1  miso output enable for the external tri-state pad buffer.
REQ-009 tx_data  input  WIDTH  next word to transmit.
REQ-010 tx_valid  input  1  tx_data valid.
REQ-011 tx_ready  output  1  one-entry transmit buffer empty.
REQ-012 rx_data  output  WIDTH  last complete received word.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 tx_underrun  output  1  one-cycle pulse when a word is loaded while the transmit buffer is empty.

Function
REQ-015 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer plus one history flop; the synchronizer reset values SHALL be sclk 0, cs_n 1, mosi 0.
REQ-016 An edge SHALL be detected when the second synchronizer stage differs from the history flop; the action SHALL be registered on the same clk edge that updates the history flop, which is the 3rd clk edge to sample the new pin level.
REQ-017 Correct operation SHALL require each sclk high and low phase to be at least 4 clk periods, and cs_n setup/hold to sclk to be at least 4 clk periods.
REQ-018 The FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE SHALL occur on a detected cs_n fall; ACTIVE->IDLE SHALL occur on a detected cs_n rise.
REQ-019 On IDLE->ACTIVE: the tx shift register SHALL load the buffer word if the buffer is full (buffer empties), else load 0 and pulse tx_underrun; the bit counter SHALL clear to 0.
REQ-020 In ACTIVE, on an sclk rise: rx_shift SHALL become {rx_shift[WIDTH-2:0], mosi_sync}, and the bit counter SHALL increment modulo WIDTH.
REQ-021 On the sclk rise where the bit counter equals WIDTH-1: rx_data SHALL be loaded with the completed word, rx_valid SHALL pulse for exactly 1 clk, and a word-done flag SHALL be set.
REQ-022 In ACTIVE, on an sclk fall with word-done set: the tx shift register SHALL reload from the buffer (or 0 with a tx_underrun pulse), and word-done SHALL clear; otherwise the tx shift register SHALL shift left one bit with 0 fill.
REQ-023 miso SHALL equal tx shift register bit WIDTH-1 in ACTIVE, and 0 in IDLE.
REQ-024 miso_oe SHALL be 1 exactly in ACTIVE.
REQ-025 tx_ready SHALL equal NOT buffer-full.
REQ-026 When tx_valid and tx_ready are both 1 on a clk edge, tx_data SHALL be captured and the buffer SHALL become full.
REQ-027 tx_valid while tx_ready is 0 SHALL be ignored.
REQ-028 A buffer consume and a capture SHALL never coincide, because tx_ready is 0 whenever the buffer is full.
REQ-029 rx has no backpressure: each completed word SHALL overwrite rx_data.
REQ-030 A cs_n rise mid-word SHALL discard the partial rx word (no rx_valid) and the tx shift register contents, and SHALL clear the bit counter and word-done; the buffer SHALL be unaffected.
REQ-031 A cs_n rise detected in the same cycle as an sclk edge SHALL take priority; the sclk edge SHALL be ignored.
REQ-032 sclk edges in IDLE SHALL be ignored.

Reset
REQ-033 While rst_n is 0, the following SHALL hold regardless of clk: state IDLE; miso 0; miso_oe 0; tx_ready 1 (buffer empty); rx_data 0; rx_valid 0; tx_underrun 0; shift registers, bit counter, word-done and synchronizers at their reset values.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no rx_valid.
REQ-035 After reset release, a frame SHALL start only on a new cs_n fall; cs_n held low across reset release SHALL not start a frame.

Verification
REQ-036 Reset: pulse rst_n low mid-frame -> miso_oe 0, tx_ready 1, rx_valid never pulses; the next frame is received correctly.
REQ-037 Single word: load tx 0xA5, master sends 0x3C -> master reads 0xA5; rx_data 0x3C with exactly one rx_valid pulse; tx_ready returns to 1 at the cs_n fall.
REQ-038 Back-to-back: load 0xA5, reload 0x5A during the first word; master sends 0x11, 0x22 in one frame -> master reads 0xA5, 0x5A; two rx_valid pulses (0x11, then 0x22); no tx_underrun.
REQ-039 Underrun: empty buffer, 2-word frame with 0xA5 preloaded -> second word reads 0x00 and exactly one tx_underrun pulse at the word-1 boundary.
REQ-040 Abort: cs_n rises after 5 sclk rises -> no rx_valid; the following full frame sending 0xC3 yields rx_data 0xC3.
REQ-041 Timing: sclk at 8 clk periods per bit -> rx_valid 3 clk edges after the 8th sclk rise; any tx_valid offered while tx_ready is 0 is ignored.
